// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide controller.
// Provides the operation encoding, FSM state codes, ALU function codes and
// small helpers that decode an operation into its divide/signed attributes.
package muldiv_pkg;

    // Operation encoding as presented on the op input.
    typedef enum logic [1:0] {
        OpMultu = 2'b00,
        OpMult  = 2'b01,
        OpDivu  = 2'b10,
        OpDiv   = 2'b11
    } op_e;

    // FSM state encoding.
    typedef logic [2:0] state_t;
    localparam state_t StIdle = 3'd0;
    localparam state_t StAbsA = 3'd1;
    localparam state_t StAbsB = 3'd2;
    localparam state_t StIter = 3'd3;
    localparam state_t StFix1 = 3'd4;
    localparam state_t StFix2 = 3'd5;
    localparam state_t StDone = 3'd6;

    // ALU function codes: F[2] inverts B and supplies carry-in, F[1:0] picks the result.
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_seq_alu.sv
// Datapath ALU shared with the main pipeline.
// Ports:
//   a_i, b_i  operands (W bits)
//   f_i       function: F[2] inverts B and sets carry-in; F[1:0] = AND, OR, ADD, SLT
//   s_o       result
//   cout_o    carry out of the adder (1 on SUB means a_i >= b_i unsigned)
//   oflow_o   signed overflow of the adder
//   zero_o    result is zero
module muldiv_seq_alu #(
    parameter int unsigned  LOGWIDTH = 5,
    localparam int unsigned W        = 1 << LOGWIDTH
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   f_i,
    output logic [W-1:0] s_o,
    output logic         cout_o,
    output logic         oflow_o,
    output logic         zero_o
);

    logic [W-1:0] b_eff;
    logic [W-1:0] sum;

    assign b_eff = f_i[2] ? ~b_i : b_i;
    assign {cout_o, sum} = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, f_i[2]};
    assign oflow_o = (a_i[W-1] == b_eff[W-1]) && (sum[W-1] != a_i[W-1]);

    always_comb begin
        s_o = '0;
        unique case (f_i[1:0])
            2'b00: s_o = a_i & b_eff;
            2'b01: s_o = a_i | b_eff;
            2'b10: s_o = sum;
            2'b11: s_o = {{(W-1){1'b0}}, sum[W-1] ^ oflow_o};
            default: s_o = '0;
        endcase
    end

    assign zero_o = (s_o == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide controller for MULT/MULTU/DIV/DIVU.
// Drives one shared ALU through shift-add multiplication and restoring
// division, and holds the HI/LO result registers.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   start         request, accepted when start & ready
//   op            00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b          multiplicand/dividend, multiplier/divisor
//   ready         able to accept a start (IDLE or DONE)
//   done          one-cycle pulse, hi/lo valid
//   div0          divisor was zero; held until the next accept
//   hi, lo        product high/low half, or remainder/quotient
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned  LOGWIDTH = 5,
    localparam int unsigned W        = 1 << LOGWIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic         div0,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam logic [LOGWIDTH:0] CntLoad = (LOGWIDTH + 1)'(W);
    localparam logic [LOGWIDTH:0] CntOne  = (LOGWIDTH + 1)'(1);

    state_t            state_q, state_d;
    op_e               op_q, op_d;
    // Multiplicand for MUL, divisor for DIV; the other operand lives in lo.
    logic [W-1:0]      opnd_q, opnd_d;
    logic [W-1:0]      hi_q, hi_d;
    logic [W-1:0]      lo_q, lo_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [LOGWIDTH:0] cnt_q, cnt_d;
    // Borrow-free flag from negating lo, needed to finish the 64-bit negate.
    logic              cout_q, cout_d;
    logic              div0_q, div0_d;

    logic [W-1:0]      alu_a, alu_b, alu_s;
    logic [2:0]        alu_f;
    logic              alu_cout, alu_oflow, alu_zero;
    logic              unused_alu_flags;

    logic              accept;
    logic              is_div, is_signed, negate;
    logic [W-1:0]      rem_s;
    logic              rem_msb, take;
    op_e               op_in;

    assign op_in     = op_e'(op);
    assign is_div    = op_is_div(op_q);
    assign is_signed = op_is_signed(op_q);
    assign negate    = sign_a_q ^ sign_b_q;

    assign ready  = (state_q == StIdle) || (state_q == StDone);
    assign done   = (state_q == StDone);
    assign accept = start && ready;

    // Restoring-division step: shift the next dividend bit into the remainder.
    // The shifted-out msb means the true remainder exceeds W bits, so the
    // subtraction always succeeds in that case.
    assign rem_s   = {hi_q[W-2:0], lo_q[W-1]};
    assign rem_msb = hi_q[W-1];
    assign take    = rem_msb | alu_cout;

    muldiv_seq_alu #(
        .LOGWIDTH (LOGWIDTH)
    ) u_alu (
        .a_i     (alu_a),
        .b_i     (alu_b),
        .f_i     (alu_f),
        .s_o     (alu_s),
        .cout_o  (alu_cout),
        .oflow_o (alu_oflow),
        .zero_o  (alu_zero)
    );

    assign unused_alu_flags = alu_oflow ^ alu_zero;

    // ALU operand and function selection.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_f = ALU_AND;
        case (state_q)
            StAbsA: begin
                alu_b = is_div ? lo_q : opnd_q;
                alu_f = ALU_SUB;
            end
            StAbsB: begin
                alu_b = is_div ? opnd_q : lo_q;
                alu_f = ALU_SUB;
            end
            StIter: begin
                alu_b = opnd_q;
                if (is_div) begin
                    alu_a = rem_s;
                    alu_f = ALU_SUB;
                end else begin
                    alu_a = hi_q;
                    alu_f = ALU_ADD;
                end
            end
            StFix1: begin
                alu_b = lo_q;
                alu_f = ALU_SUB;
            end
            StFix2: begin
                alu_b = hi_q;
                if (!is_div && !cout_q) begin
                    // Low half was nonzero, so the high half of -x is just ~hi.
                    alu_a = '1;
                    alu_f = ALU_ANDN;
                end else begin
                    alu_f = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        cout_d   = cout_q;
        div0_d   = div0_q;

        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    op_d     = op_in;
                    sign_a_d = op_is_signed(op_in) & a[W-1];
                    sign_b_d = op_is_signed(op_in) & b[W-1];
                    cnt_d    = CntLoad;
                    hi_d     = '0;
                    lo_d     = op_is_div(op_in) ? a : b;
                    opnd_d   = op_is_div(op_in) ? b : a;
                    div0_d   = op_is_div(op_in) & (b == '0);
                    cout_d   = 1'b0;
                    state_d  = op_is_signed(op_in) ? StAbsA : StIter;
                end else begin
                    state_d = StIdle;
                end
            end
            StAbsA: begin
                if (sign_a_q) begin
                    if (is_div) lo_d = alu_s;
                    else        opnd_d = alu_s;
                end
                state_d = StAbsB;
            end
            StAbsB: begin
                if (sign_b_q) begin
                    if (is_div) opnd_d = alu_s;
                    else        lo_d = alu_s;
                end
                state_d = StIter;
            end
            StIter: begin
                cnt_d = cnt_q - CntOne;
                if (is_div) begin
                    hi_d = take ? alu_s : rem_s;
                    lo_d = {lo_q[W-2:0], take};
                end else if (lo_q[0]) begin
                    hi_d = {alu_cout, alu_s[W-1:1]};
                    lo_d = {alu_s[0], lo_q[W-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[W-1:1]};
                    lo_d = {hi_q[0], lo_q[W-1:1]};
                end
                if (cnt_q == CntOne) begin
                    state_d = is_signed ? StFix1 : StDone;
                end
            end
            StFix1: begin
                if (negate) begin
                    lo_d = alu_s;
                    if (!is_div) cout_d = alu_cout;
                end
                state_d = StFix2;
            end
            StFix2: begin
                if (is_div ? sign_a_q : negate) hi_d = alu_s;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= OpMultu;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            cout_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            cout_q   <= cout_d;
            div0_q   <= div0_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with hand-computed results.
module tb_muldiv_seq;

    localparam int unsigned LOGWIDTH = 5;
    localparam int unsigned W        = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         ready, done, div0;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    muldiv_seq #(
        .LOGWIDTH (LOGWIDTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .div0    (div0),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
    endtask

    // Counts negedges after the accept edge until done; n0 already consumed.
    task automatic wait_done(input string tag, input int n0, input int exp_lat, output int got);
        got = n0;
        while (got < 80) begin
            @(negedge clk);
            got++;
            if (done) break;
        end
        check_eq({tag, " latency"}, got, exp_lat);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] exp_hi,
                             input logic [W-1:0] exp_lo, input logic exp_div0);
        check_eq({tag, " hi"}, hi, exp_hi);
        check_eq({tag, " lo"}, lo, exp_lo);
        check_eq({tag, " div0"}, div0, exp_div0);
        check_eq({tag, " ready"}, ready, 1'b1);
    endtask

    initial begin
        reset_n = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        #2 reset_n = 1'b0;
        #10;
        check_eq("reset hi", hi, 0);
        check_eq("reset lo", lo, 0);
        check_eq("reset done", done, 0);
        check_eq("reset div0", div0, 0);
        check_eq("reset ready", ready, 1);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu max", 0, 33, lat);
        check_res("multu max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);
        check_eq("done pulse", done, 0);
        check_eq("hi held", hi, 32'hFFFF_FFFE);

        issue(2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_done("mult -3*5", 0, 37, lat);
        check_res("mult -3*5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        @(negedge clk);

        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult min*min", 0, 37, lat);
        check_res("mult min*min", 32'h4000_0000, 32'h0000_0000, 1'b0);
        @(negedge clk);

        issue(2'b10, 32'd100, 32'd7);
        wait_done("divu 100/7", 0, 33, lat);
        check_res("divu 100/7", 32'h0000_0002, 32'h0000_000E, 1'b0);
        @(negedge clk);

        issue(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done("div -7/2", 0, 37, lat);
        check_res("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);

        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div min/-1", 0, 37, lat);
        check_res("div min/-1", 32'h0000_0000, 32'h8000_0000, 1'b0);
        @(negedge clk);

        issue(2'b10, 32'd7, 32'd0);
        wait_done("divu 7/0", 0, 33, lat);
        check_res("divu 7/0", 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        check_eq("div0 held", div0, 1);

        // A start during ITER must be ignored.
        issue(2'b00, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        check_eq("busy ready", ready, 0);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd99;
        b     = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignored start", 5, 33, lat);
        check_res("ignored start", 32'h0000_0000, 32'h0000_000F, 1'b0);

        // Back-to-back issue from the DONE cycle.
        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        wait_done("back2back", 0, 33, lat);
        check_res("back2back", 32'h0000_0001, 32'h0000_0000, 1'b0);
        @(negedge clk);

        // Reset in the middle of ITER.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midreset hi", hi, 0);
        check_eq("midreset lo", lo, 0);
        check_eq("midreset ready", ready, 1);
        check_eq("midreset done", done, 0);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'd6, 32'd7);
        wait_done("multu 6*7", 0, 33, lat);
        check_res("multu 6*7", 32'h0000_0000, 32'h0000_002A, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
